m_dmem_ctrl: RTL and testbench
==============================

# m_dmem_ctrl

Data-memory access controller that sits directly downstream of the RV32I core's load/store port.
- Accepts one load or store per access from the core and performs sub-word byte-lane steering, sign/zero extension and alignment checking.
- Runs a req/ack handshake with the data SRAM and drives the core's stall input until the access completes.
- Supplies D_IN for loads and generates w_stall, so the core's two-state sequencing holds while memory is busy.

## Interface
Parameters:
- ADDR_W, 14, word-address width toward SRAM; 2^ADDR_W words.
- TIMEOUT, 255, maximum cycles in REQ without m_ack before the access is aborted; range 1..255.

Ports:
- w_clk  in  1  clock.
- r_rst  in  1  reset, synchronous, active-low.
- i_re  in  1  load request (core D_RE).
- i_we  in  1  store request (core D_WE).
- i_addr  in  32  byte address (core D_ADDR).
- i_wdata  in  32  store data, right-aligned (core D_OUT).
- i_fct3  in  3  funct3 of the load/store: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- o_rdata  out  32  extended load result (core D_IN).
- o_stall  out  1  core stall (core w_stall).
- o_misalign  out  1  one-cycle pulse: misaligned access rejected.
- o_err  out  1  one-cycle pulse: timeout abort.
- m_req  out  1  SRAM request; held until m_ack.
- m_we  out  1  SRAM write.
- m_addr  out  ADDR_W  SRAM word address = i_addr[ADDR_W+1:2]; upper address bits are ignored.
- m_be  out  4  byte enables for stores; 4'b0000 for loads.
- m_wdata  out  32  lane-replicated store data.
- m_ack  in  1  SRAM completion; m_rdata is valid in the same cycle.
- m_rdata  in  32  SRAM word read data.

## Operation
FSM states: IDLE, REQ, DONE.
- IDLE, no request (i_re=i_we=0): remain in IDLE.
- IDLE, request present:
  - Alignment check: H/HU requires addr[0]=0; W requires addr[1:0]=0.
  - If misaligned: stay in IDLE, assert o_misalign next cycle, no SRAM request, o_rdata=0.
  - If aligned: register m_addr, m_we, m_be and m_wdata, then go to REQ.
- i_re and i_we both high: treated as a store; the read is ignored.
- Store lanes:
  - B: m_wdata={4{wdata[7:0]}}, m_be=1<<addr[1:0].
  - H: m_wdata={2{wdata[15:0]}}, m_be=addr[1]?1100:0011.
  - W: m_be=1111.
- REQ:
  - m_req=1 for every cycle in REQ.
  - A 8-bit counter increments each cycle.
  - On m_ack: capture the extended load result into o_rdata (loads only), go to DONE.
  - If the counter reaches TIMEOUT without m_ack: o_rdata=32'hDEADBEEF, pulse o_err, go to DONE.
- Load extract: select byte/half by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- DONE: lasts one cycle, ignores inputs, clears the counter, returns to IDLE. o_rdata holds its value until the next load completes.
- m_ack in IDLE or DONE is ignored.
- o_stall (combinational) = r_rst & ((IDLE & (i_re|i_we) & aligned) | REQ).
- Reset (r_rst=0 at a clock edge), from any state:
  - state → IDLE; counter=0; m_req=0.
  - m_we, m_be, m_addr, m_wdata, o_rdata all 0; o_misalign=0, o_err=0.
  - An in-flight SRAM access is abandoned; its later ack is ignored.

## Timing
- Cycle 0: aligned request seen in IDLE; o_stall=1.
- Cycle 1: REQ, m_req=1. Ack earliest in cycle 1.
- Cycle ack+1: DONE; o_stall=0, o_rdata valid; the core advances at the end of this cycle.
- Minimum access: 2 stalled cycles plus the DONE cycle. Each extra SRAM wait cycle adds 1.
- Timeout abort: DONE occurs at cycle TIMEOUT+1.
- o_misalign and o_err assert the cycle after detection, for exactly 1 cycle.
- The core holds i_* stable while o_stall=1; the block samples them only in IDLE.

## Structure
- Shared package: funct3 constants (LS_B, LS_H, LS_W, LS_BU, LS_HU), FSM state encoding, and the DEADBEEF abort value.
- One natural sub-module: m_ld_extract (combinational lane select plus sign/zero extension). It is reused by any future byte-addressable port.

## Test plan
- LW addr 0x10, SRAM acks after 1 cycle with 0x89ABCDEF → o_rdata=0x89ABCDEF in DONE; o_stall high exactly 2 cycles.
- LB addr 0x13, m_rdata 0x80FF1234 → 0xFFFFFF80; LBU same access → 0x00000080; LHU addr 0x12 → 0x000080FF.
- SH addr 0x22, wdata 0x0000BEEF → m_addr=0x8, m_be=1100, m_wdata=0xBEEFBEEF, m_we=1.
- LW addr 0x11 → no m_req, o_misalign pulse, o_stall=0, o_rdata=0.
- TIMEOUT=4, no ack → m_req high 4 cycles, o_err pulse, o_rdata=0xDEADBEEF, back in IDLE.
- r_rst=0 in the middle of REQ, then ack arrives in IDLE → all outputs 0; ack ignored; the next LW completes normally.

Source files
------------

// File: rtl/m_dmem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller:
// load/store funct3 codes, FSM encoding and the timeout abort value.
package m_dmem_ctrl_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  localparam int unsigned CNT_W      = 8;
  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // funct3[1:0] carries the access size; bytes are always aligned
  function automatic logic ls_aligned(input logic [2:0] fct3, input logic [1:0] off);
    case (fct3[1:0])
      2'b00:   return 1'b1;
      2'b01:   return ~off[0];
      default: return (off == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/m_dmem_ctrl_if.sv
// Data SRAM req/ack bus between the access controller (master) and the SRAM (slave).
interface m_dmem_ctrl_if #(
  parameter int unsigned ADDR_W = 14
) ();

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [3:0]        m_be;
  logic [31:0]       m_wdata;
  logic              m_ack;
  logic [31:0]       m_rdata;

  modport master (
    output m_req, m_we, m_addr, m_be, m_wdata,
    input  m_ack, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_be, m_wdata,
    output m_ack, m_rdata
  );

endinterface

// File: rtl/m_dmem_ctrl_ld_extract.sv
// Load lane select with sign/zero extension; combinational, shared by byte-addressable ports.
module m_ld_extract
  import m_dmem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  fct3,
  output logic [31:0] data_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'h00;
    case (off)
      2'd0: byte_v = word[7:0];
      2'd1: byte_v = word[15:8];
      2'd2: byte_v = word[23:16];
      2'd3: byte_v = word[31:24];
      default: byte_v = 8'h00;
    endcase
    half_v = off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data_c = word;
    case (fct3)
      LS_B:    data_c = {{24{byte_v[7]}}, byte_v};
      LS_BU:   data_c = {24'h000000, byte_v};
      LS_H:    data_c = {{16{half_v[15]}}, half_v};
      LS_HU:   data_c = {16'h0000, half_v};
      LS_W:    data_c = word;
      default: data_c = word;
    endcase
  end

endmodule

// File: rtl/m_dmem_ctrl.sv
// Data-memory access controller: steers core loads/stores onto the SRAM req/ack bus,
// stalls the core while the access is in flight and returns extended load data.
module m_dmem_ctrl
  import m_dmem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        w_clk,
  input  logic        r_rst,
  input  logic        i_re,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_fct3,
  output logic [31:0] o_rdata,
  output logic        o_stall,
  output logic        o_misalign,
  output logic        o_err,
  m_dmem_ctrl_if.master mem
);

  // Counter value in the last REQ cycle before the abort
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        off_q;
  logic [2:0]        fct3_q;
  logic              load_q;

  logic              req_c, aligned_c;
  logic              issue_c, reject_c, capture_c, abort_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c, ext_c;
  logic              unused_addr_hi;

  assign req_c          = i_re | i_we;
  assign aligned_c      = ls_aligned(i_fct3, i_addr[1:0]);
  assign unused_addr_hi = ^i_addr[31:ADDR_W+2];

  always_ff @(posedge w_clk) begin
    if (!r_rst) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    issue_c   = 1'b0;
    reject_c  = 1'b0;
    capture_c = 1'b0;
    abort_c   = 1'b0;
    case (state)
      IDLE: begin
        if (req_c) begin
          if (aligned_c) begin
            issue_c = 1'b1;
            state_d = REQ;
          end else begin
            reject_c = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem.m_ack) begin
          capture_c = 1'b1;
          state_d   = DONE;
        end else if (cnt == CNT_LAST) begin
          abort_c = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_stall = r_rst & (((state == IDLE) & req_c & aligned_c) | (state == REQ));

  // Store lane steering; a simultaneous read request is dropped in favour of the store
  always_comb begin
    be_c    = 4'b0000;
    wdata_c = 32'h0000_0000;
    if (i_we) begin
      case (i_fct3[1:0])
        2'b00: begin
          be_c    = 4'(4'b0001 << i_addr[1:0]);
          wdata_c = {4{i_wdata[7:0]}};
        end
        2'b01: begin
          be_c    = i_addr[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{i_wdata[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wdata_c = i_wdata;
        end
      endcase
    end
  end

  m_ld_extract u_ld_extract (
    .word   (mem.m_rdata),
    .off    (off_q),
    .fct3   (fct3_q),
    .data_c (ext_c)
  );

  always_ff @(posedge w_clk) begin
    if (!r_rst) begin
      cnt         <= '0;
      off_q       <= 2'b00;
      fct3_q      <= 3'b000;
      load_q      <= 1'b0;
      mem.m_req   <= 1'b0;
      mem.m_we    <= 1'b0;
      mem.m_addr  <= '0;
      mem.m_be    <= 4'b0000;
      mem.m_wdata <= 32'h0000_0000;
      o_rdata     <= 32'h0000_0000;
      o_misalign  <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_misalign <= reject_c;
      o_err      <= abort_c;
      cnt        <= (state == REQ) ? cnt + CNT_W'(1) : '0;
      if (issue_c) begin
        mem.m_req   <= 1'b1;
        mem.m_we    <= i_we;
        mem.m_addr  <= i_addr[ADDR_W+1:2];
        mem.m_be    <= be_c;
        mem.m_wdata <= wdata_c;
        off_q       <= i_addr[1:0];
        fct3_q      <= i_fct3;
        load_q      <= ~i_we;
      end
      if (capture_c || abort_c) mem.m_req <= 1'b0;
      if (reject_c)                  o_rdata <= 32'h0000_0000;
      else if (abort_c)              o_rdata <= ABORT_DATA;
      else if (capture_c && load_q)  o_rdata <= ext_c;
    end
  end

endmodule

// File: tb/tb_m_dmem_ctrl.sv
// Self-checking bench for m_dmem_ctrl: directed cases plus randomized loads/stores
// against a word-array memory model with arithmetic lane extraction.
module tb_m_dmem_ctrl;
  import m_dmem_ctrl_pkg::*;

  logic        w_clk = 1'b0;
  logic        r_rst = 1'b0;
  logic        i_re = 1'b0, i_we = 1'b0;
  logic [31:0] i_addr = '0, i_wdata = '0;
  logic [2:0]  i_fct3 = '0;
  logic [31:0] o_rdata;
  logic        o_stall, o_misalign, o_err;

  m_dmem_ctrl_if #(.ADDR_W(14)) bus ();

  m_dmem_ctrl #(.ADDR_W(14), .TIMEOUT(4)) dut (
    .w_clk(w_clk), .r_rst(r_rst), .i_re(i_re), .i_we(i_we), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_fct3(i_fct3), .o_rdata(o_rdata), .o_stall(o_stall),
    .o_misalign(o_misalign), .o_err(o_err), .mem(bus)
  );

  always #5 w_clk = ~w_clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          ack_lat = -1;
  int          wait_cnt = 0;
  logic        stray_ack = 1'b0;
  bit   [31:0] sram    [256];
  bit   [31:0] ref_mem [256];
  logic [31:0] model_rdata = '0;

  // SRAM responder: acks after ack_lat wait cycles (never when negative)
  always @(negedge w_clk) begin
    if (stray_ack) begin
      bus.m_ack   = 1'b1;
      bus.m_rdata = 32'h1234_5678;
    end else if (bus.m_req && ack_lat >= 0 && wait_cnt >= ack_lat) begin
      bus.m_ack   = 1'b1;
      bus.m_rdata = sram[bus.m_addr[7:0]];
      if (bus.m_we)
        for (int i = 0; i < 4; i++)
          if (bus.m_be[i]) sram[bus.m_addr[7:0]][8*i +: 8] = bus.m_wdata[8*i +: 8];
      wait_cnt = 0;
    end else begin
      bus.m_ack   = 1'b0;
      bus.m_rdata = 32'h0;
      wait_cnt    = bus.m_req ? wait_cnt + 1 : 0;
    end
  end

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (off * 8)) & 32'hFF;
    h = (w >> (off[1] * 16)) & 32'hFFFF;
    case (f3)
      LS_B:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      LS_BU:   return b;
      LS_H:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      LS_HU:   return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'(1 << off);
      2'b01:   return 4'(3 << (off[1] * 2));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return (wd & 32'hFF) * 32'h0101_0101;
      2'b01:   return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd);
    logic [3:0]  be;
    logic [31:0] rep, mask;
    be  = ref_be(f3, addr[1:0]);
    rep = ref_wdata(f3, wd);
    for (int i = 0; i < 4; i++) begin
      mask = 32'hFF << (8 * i);
      if (be[i]) ref_mem[addr[9:2]] = (ref_mem[addr[9:2]] & ~mask) | (rep & mask);
    end
  endtask

  // Drives one core access and observes it until DONE (or the rejection cycle)
  task automatic run_access(input logic re, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [2:0] f3, input int lat,
                            output int stall_n, output int req_n, output logic [31:0] rd,
                            output logic err, output logic mis, output logic [3:0] be,
                            output logic [31:0] mwd, output logic [13:0] ma,
                            output logic mwe, output logic timed_out);
    @(negedge w_clk);
    i_re = re; i_we = we; i_addr = addr; i_wdata = wd; i_fct3 = f3; ack_lat = lat;
    stall_n = 0; req_n = 0; rd = '0; err = 0; mis = 0; be = '0; mwd = '0; ma = '0;
    mwe = 0; timed_out = 0;
    #1;
    if (!o_stall) begin
      @(negedge w_clk);
      i_re = 0; i_we = 0;
      #1;
      mis = o_misalign; rd = o_rdata; req_n = int'(bus.m_req);
      return;
    end
    stall_n = 1;
    for (int c = 0; c < 300; c++) begin
      @(negedge w_clk);
      #1;
      if (bus.m_req) begin
        if (req_n == 0) begin
          be = bus.m_be; mwd = bus.m_wdata; ma = bus.m_addr; mwe = bus.m_we;
        end
        req_n++;
      end
      if (o_stall) stall_n++;
      else begin
        rd = o_rdata; err = o_err; mis = o_misalign;
        i_re = 0; i_we = 0;
        return;
      end
    end
    timed_out = 1; i_re = 0; i_we = 0;
  endtask

  int          s_n, r_n;
  logic [31:0] rd, mwd;
  logic        err, mis, mwe, tmo;
  logic [3:0]  be;
  logic [13:0] ma;

  task automatic test_reset;
    repeat (3) @(negedge w_clk);
    #1;
    n_tests++; if (bus.m_req !== 1'b0) begin n_fail++; $display("FAIL reset_m_req: got %b want 0", bus.m_req); end
    n_tests++; if (o_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", o_rdata); end
    n_tests++; if ({o_stall, o_misalign, o_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {o_stall, o_misalign, o_err}); end
    n_tests++; if ({bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata} !== '0) begin n_fail++; $display("FAIL reset_bus: got %h want 0", {bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata}); end
    r_rst = 1'b1;
  endtask

  task automatic test_lw;
    sram[4] = 32'h89AB_CDEF; ref_mem[4] = 32'h89AB_CDEF;
    run_access(1, 0, 32'h10, 0, LS_W, 0, s_n, r_n, rd, err, mis, be, mwd, ma, mwe, tmo);
    n_tests++; if (rd !== 32'h89AB_CDEF) begin n_fail++; $display("FAIL lw_data: got %h want 89abcdef", rd); end
    n_tests++; if (s_n !== 2) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d want 2", s_n); end
    n_tests++; if (r_n !== 1 || err !== 1'b0) begin n_fail++; $display("FAIL lw_req_cycles: got %0d err %b want 1 err 0", r_n, err); end
    model_rdata = 32'h89AB_CDEF;
  endtask

  task automatic test_load_ext;
    logic [31:0] exp_v [3];
    logic [31:0] adr   [3];
    logic [2:0]  f3    [3];
    int          lat;
    sram[4] = 32'h80FF_1234; ref_mem[4] = 32'h80FF_1234;
    exp_v = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
    adr   = '{32'h13, 32'h13, 32'h12};
    f3    = '{LS_B, LS_BU, LS_HU};
    for (int k = 0; k < 3; k++) begin
      lat = $urandom_range(0, 2);
      run_access(1, 0, adr[k], 0, f3[k], lat, s_n, r_n, rd, err, mis, be, mwd, ma, mwe, tmo);
      n_tests++; if (rd !== exp_v[k]) begin n_fail++; $display("FAIL load_ext_%0d: got %h want %h", k, rd, exp_v[k]); end
      n_tests++; if (s_n !== lat + 2) begin n_fail++; $display("FAIL load_ext_stall_%0d: got %0d want %0d", k, s_n, lat + 2); end
    end
    model_rdata = exp_v[2];
  endtask

  task automatic test_store;
    logic [31:0] exp_w;
    run_access(0, 1, 32'h22, 32'h0000_BEEF, LS_H, 0, s_n, r_n, rd, err, mis, be, mwd, ma, mwe, tmo);
    n_tests++; if (ma !== 14'h8) begin n_fail++; $display("FAIL sh_addr: got %h want 8", ma); end
    n_tests++; if (be !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b want 1100", be); end
    n_tests++; if (mwd !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL sh_wdata: got %h want beefbeef", mwd); end
    n_tests++; if (mwe !== 1'b1) begin n_fail++; $display("FAIL sh_we: got %b want 1", mwe); end
    n_tests++; if (rd !== model_rdata) begin n_fail++; $display("FAIL sh_rdata_hold: got %h want %h", rd, model_rdata); end
    ref_store(32'h22, LS_H, 32'h0000_BEEF);
    exp_w = ref_mem[8];
    run_access(1, 0, 32'h20, 0, LS_W, 1, s_n, r_n, rd, err, mis, be, mwd, ma, mwe, tmo);
    n_tests++; if (rd !== exp_w) begin n_fail++; $display("FAIL sh_readback: got %h want %h", rd, exp_w); end
    n_tests++; if (be !== 4'b0000) begin n_fail++; $display("FAIL load_be: got %b want 0000", be); end
    model_rdata = exp_w;
  endtask

  task automatic test_misalign;
    run_access(1, 0, 32'h11, 0, LS_W, 0, s_n, r_n, rd, err, mis, be, mwd, ma, mwe, tmo);
    n_tests++; if (mis !== 1'b1) begin n_fail++; $display("FAIL misalign_pulse: got %b want 1", mis); end
    n_tests++; if (s_n !== 0 || r_n !== 0) begin n_fail++; $display("FAIL misalign_no_req: stall %0d req %0d want 0 0", s_n, r_n); end
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL misalign_rdata: got %h want 0", rd); end
    @(negedge w_clk); #1;
    n_tests++; if (o_misalign !== 1'b0 || bus.m_req !== 1'b0) begin n_fail++; $display("FAIL misalign_one_cycle: mis %b req %b want 0 0", o_misalign, bus.m_req); end
    model_rdata = 32'h0;
  endtask

  task automatic test_timeout;
    run_access(1, 0, 32'h30, 0, LS_W, -1, s_n, r_n, rd, err, mis, be, mwd, ma, mwe, tmo);
    n_tests++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL timeout_bound: access never finished"); end
    n_tests++; if (r_n !== 4) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d want 4", r_n); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", err); end
    n_tests++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL timeout_rdata: got %h want deadbeef", rd); end
    @(negedge w_clk); #1;
    n_tests++; if ({o_err, o_stall, bus.m_req} !== 3'b000) begin n_fail++; $display("FAIL timeout_idle: got %b want 000", {o_err, o_stall, bus.m_req}); end
    model_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset_midflight;
    @(negedge w_clk);
    i_we = 1; i_re = 0; i_addr = 32'h40; i_wdata = 32'hCAFE_F00D; i_fct3 = LS_W; ack_lat = -1;
    @(negedge w_clk); @(negedge w_clk); #1;
    n_tests++; if (bus.m_req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_req: got %b want 1", bus.m_req); end
    r_rst = 1'b0;
    #1;
    n_tests++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall_gate: got %b want 0", o_stall); end
    @(negedge w_clk); #1;
    n_tests++; if ({bus.m_req, bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata} !== '0) begin n_fail++; $display("FAIL rst_bus_clear: got %h want 0", {bus.m_req, bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata}); end
    n_tests++; if ({o_rdata, o_err, o_misalign} !== '0) begin n_fail++; $display("FAIL rst_out_clear: got %h want 0", {o_rdata, o_err, o_misalign}); end
    i_we = 0; r_rst = 1'b1; stray_ack = 1'b1;
    @(negedge w_clk); #1;
    stray_ack = 1'b0;
    @(negedge w_clk); #1;
    n_tests++; if ({o_rdata, o_stall, bus.m_req} !== '0) begin n_fail++; $display("FAIL rst_stray_ack: got %h want 0", {o_rdata, o_stall, bus.m_req}); end
    run_access(1, 0, 32'h40, 0, LS_W, 1, s_n, r_n, rd, err, mis, be, mwd, ma, mwe, tmo);
    n_tests++; if (rd !== ref_mem[16] || s_n !== 3) begin n_fail++; $display("FAIL rst_next_lw: got %h/%0d want %h/3", rd, s_n, ref_mem[16]); end
    model_rdata = ref_mem[16];
  endtask

  task automatic test_random_back_to_back;
    logic [2:0]  f3_tab [8];
    logic [2:0]  f3;
    logic [31:0] addr, wd, exp_v;
    logic        st, ok;
    int          kind, lat;
    f3_tab = '{LS_B, LS_H, LS_W, LS_BU, LS_HU, LS_B, LS_H, LS_W};
    for (int it = 0; it < 80; it++) begin
      kind = $urandom_range(0, 7);
      f3   = f3_tab[kind];
      st   = (kind >= 5);
      addr = $urandom;
      wd   = $urandom;
      lat  = $urandom_range(0, 3);
      if ($urandom_range(0, 5) != 0) begin
        if (f3[1:0] == 2'b01) addr = addr & ~32'h1;
        if (f3[1:0] == 2'b10) addr = addr & ~32'h3;
      end
      ok = (f3[1:0] == 2'b00) || (f3[1:0] == 2'b01 && addr % 2 == 0) || (addr % 4 == 0);
      run_access(st ? 1'($urandom_range(0, 1)) : 1'b1, st, addr, wd, f3, lat,
                 s_n, r_n, rd, err, mis, be, mwd, ma, mwe, tmo);
      if (!ok) begin
        n_tests++; if (mis !== 1'b1 || rd !== 32'h0 || r_n !== 0) begin n_fail++; $display("FAIL rnd_misalign it%0d: mis %b rd %h req %0d", it, mis, rd, r_n); end
        model_rdata = 32'h0;
        continue;
      end
      n_tests++; if (tmo !== 1'b0 || s_n !== lat + 2 || r_n !== lat + 1 || err !== 1'b0) begin n_fail++; $display("FAIL rnd_timing it%0d: stall %0d req %0d err %b want %0d %0d 0", it, s_n, r_n, err, lat + 2, lat + 1); end
      if (st) begin
        n_tests++; if (be !== ref_be(f3, addr[1:0]) || mwd !== ref_wdata(f3, wd) || ma !== addr[15:2] || mwe !== 1'b1) begin n_fail++; $display("FAIL rnd_store it%0d: be %b wd %h a %h we %b want %b %h %h 1", it, be, mwd, ma, mwe, ref_be(f3, addr[1:0]), ref_wdata(f3, wd), addr[15:2]); end
        ref_store(addr, f3, wd);
        n_tests++; if (rd !== model_rdata) begin n_fail++; $display("FAIL rnd_store_hold it%0d: got %h want %h", it, rd, model_rdata); end
      end else begin
        exp_v = ref_load(ref_mem[addr[9:2]], addr[1:0], f3);
        n_tests++; if (rd !== exp_v) begin n_fail++; $display("FAIL rnd_load it%0d f3 %b addr %h: got %h want %h", it, f3, addr, rd, exp_v); end
        model_rdata = exp_v;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]    = $urandom;
      ref_mem[i] = sram[i];
    end
    test_reset;
    test_lw;
    test_load_ext;
    test_store;
    test_misalign;
    test_timeout;
    test_reset_midflight;
    test_random_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
